cond_ctl: RTL
=============

Name: cond_ctl

Overview:
- Clocked controller that drives the dual-rail control channel (ctl_a/ctl_b, ack actl_i) of a cond_sink stage.
- It snoops the bundled-data token presented to cond_sink (r_i/d_i) and issues exactly one keep/drop decision per token.
- Each decision completes a full 4-phase return-to-zero handshake.
- Sits directly upstream of cond_sink's control input. It is the synchronous policy engine for an otherwise self-timed filter path.

Parameters:
- N, 32, width of snooped data d_i and of match_val/match_mask.
- SYNC_STAGES, 2, flops per input synchronizer (min 2).
- CNT_W, 16, width of kept_cnt/drop_cnt.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-low reset (rst=0 => reset).
- r_i  input  1  request of token entering cond_sink; asynchronous, snoop only.
- d_i  input  N  bundled data of that token; stable while r_i high.
- ctl_a  output  1  rail A: keep (demux routes token to r_o/d_o).
- ctl_b  output  1  rail B: drop (demux routes token to sink).
- actl_i  input  1  control-channel acknowledge from cond_sink; asynchronous.
- match_val  input  N  compare value (quasi-static).
- match_mask  input  N  compare mask; 1 = bit participates.
- invert  input  1  1 => keep non-matching tokens instead.
- busy  output  1  high whenever state != IDLE.
- kept_cnt  output  CNT_W  tokens kept, saturating.
- drop_cnt  output  CNT_W  tokens dropped, saturating.

Behaviour:
- r_i and actl_i each pass through a SYNC_STAGES synchronizer; rs and as denote the synchronized signals. d_i is never synchronized; it is sampled only while rs=1 (bundling guarantees stability).
- Reset (rst=0, asynchronous): state=IDLE; ctl_a=0, ctl_b=0, busy=0, kept_cnt=0, drop_cnt=0; synchronizers cleared. Reset mid-handshake drops the rails immediately. The cond_sink stage must be reset concurrently.
- match = ((d_i ^ match_val) & match_mask) == 0; keep = match ^ invert.
- FSM:
  - IDLE: if rs=1 and as=0, go to DECIDE. Sample d_i, match_val, match_mask and invert into registers on that same edge.
  - DECIDE (1 cycle): compute keep from the sampled values and go to ASSERT.
  - ASSERT: ctl_a=keep, ctl_b=~keep (registered, exactly one rail high). Increment kept_cnt or drop_cnt on the entry edge. Stay until as=1, then go to RTZ.
  - RTZ: ctl_a=ctl_b=0. Stay until as=0 and rs=0, then go to IDLE. Waiting for rs=0 guarantees one decision per token.
- Latency:
  - Rail asserts SYNC_STAGES+2 clock edges after r_i rises (r_i rise ahead of setup).
  - Rails fall SYNC_STAGES+1 edges after actl_i rises.
- Rails are never both high. Rails never change while in ASSERT.
- Configuration changes take effect at the next token. The in-flight decision uses the values sampled in IDLE.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- If r_i is still high on RTZ exit, it is not a new token; the FSM waits for its fall.
- If actl_i is high on reset exit, IDLE does not start a decision until as=0.

Optional Feature:
- Macro COND_CTL_DECIM_EN.
- Defined:
  - Adds input decim (8 bits) and an internal 8-bit decimation counter dcnt, reset to 0.
  - For tokens where keep=1: keep only when dcnt==0, else force drop.
  - dcnt increments modulo (decim+1) on each keep=1 token, evaluated in DECIDE.
  - decim=0 leaves behaviour identical to the undefined case.
  - keep=0 tokens do not advance dcnt.
- Undefined: no decim port, no counter; keep as above.

Decomposition:
- Package cond_ctl_pkg:
  - state enum {IDLE, DECIDE, ASSERT, RTZ};
  - rail encoding constants RAIL_NULL=2'b00, RAIL_KEEP=2'b01 ({ctl_b,ctl_a}), RAIL_DROP=2'b10;
  - default DECIM_W=8.
- One sub-module, sync_ff: SYNC_STAGES-deep synchronizer with async active-low clear. Instantiated twice (r_i, actl_i).

Test Plan:
- Reset then idle: rst=0 with r_i=1 → ctl_a=ctl_b=0, counters 0, busy=0. Release rst with r_i=0 → no rail activity for 20 cycles.
- Match keep: mask=0xFF, val=0x5A, d_i=0x1234565A, invert=0 → ctl_a=1 at SYNC_STAGES+2 edges after r_i rise. Ack 4-phase → rails 0, kept_cnt=1.
- Mismatch/invert: d_i=0x5B, val=0x5A, mask=0xFF gives ctl_b=1, drop_cnt=1. Repeat with invert=1 → ctl_a=1, kept_cnt=1.
- Held r_i/slow ack: r_i stays high 10 cycles after actl_i falls → exactly one decision; busy until r_i falls. Rails never both high (assertion).
- Saturation: CNT_W=4, 20 matching tokens → kept_cnt=15, drop_cnt=0.
- Decimation with COND_CTL_DECIM_EN, decim=2, 7 matching tokens → keep pattern K,D,D,K,D,D,K; kept_cnt=3, drop_cnt=4.

Source files
------------

// File: rtl/cond_ctl_pkg.sv
// Shared types and constants for the cond_ctl keep/drop controller.
package cond_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    ASSERT,
    RTZ
  } state_e;

  // Dual-rail encoding as {ctl_b, ctl_a}
  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_KEEP = 2'b01;
  localparam logic [1:0] RAIL_DROP = 2'b10;

  localparam int unsigned DECIM_W = 8;

  function automatic logic [1:0] rail_of(input logic keep);
    return keep ? RAIL_KEEP : RAIL_DROP;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, with async active-low clear.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d};
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/cond_ctl.sv
// Synchronous keep/drop policy engine driving the dual-rail control channel of cond_sink.
// Optional decimation of kept tokens is enabled with the COND_CTL_DECIM_EN macro.
module cond_ctl
  import cond_ctl_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r_i,
  input  logic [N-1:0]       d_i,
  output logic               ctl_a,
  output logic               ctl_b,
  input  logic               actl_i,
  input  logic [N-1:0]       match_val,
  input  logic [N-1:0]       match_mask,
  input  logic               invert,
`ifdef COND_CTL_DECIM_EN
  input  logic [DECIM_W-1:0] decim,
`endif
  output logic               busy,
  output logic [CNT_W-1:0]   kept_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  logic req_s, ack_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (r_i),
    .q   (req_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (actl_i),
    .q   (ack_s)
  );

  state_e           state_q, state_d;
  logic [N-1:0]     d_q, val_q, mask_q;
  logic             inv_q;
  logic [1:0]       rail_q, rail_d;
  logic [CNT_W-1:0] kept_q, kept_d, drop_q, drop_d;
  logic             take, keep_raw, keep_dec;

  // d_i is bundled with r_i, so it is only captured once the synchronized request is seen
  assign take     = (state_q == IDLE) && req_s && !ack_s;
  assign keep_raw = ((((d_q ^ val_q) & mask_q) == '0)) ^ inv_q;

`ifdef COND_CTL_DECIM_EN
  logic [DECIM_W-1:0] decim_q, dcnt_q, dcnt_d;

  assign keep_dec = keep_raw && (dcnt_q == '0);

  always_comb begin
    dcnt_d = dcnt_q;
    if (state_q == DECIDE && keep_raw) begin
      dcnt_d = (dcnt_q >= decim_q) ? '0 : dcnt_q + DECIM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decim_q <= '0;
      dcnt_q  <= '0;
    end else begin
      if (take) decim_q <= decim;
      dcnt_q <= dcnt_d;
    end
  end
`else
  assign keep_dec = keep_raw;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_s && !ack_s) state_d = DECIDE;
      DECIDE:  state_d = ASSERT;
      ASSERT:  if (ack_s) state_d = RTZ;
      // Waiting for the request to fall keeps a held r_i from counting as a second token
      RTZ:     if (!ack_s && !req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rail_d = RAIL_NULL;
    if (state_q == DECIDE) begin
      rail_d = rail_of(keep_dec);
    end else if (state_q == ASSERT && !ack_s) begin
      rail_d = rail_q;
    end
    busy = (state_q != IDLE);
  end

  always_comb begin
    kept_d = kept_q;
    drop_d = drop_q;
    if (state_q == DECIDE) begin
      if (keep_dec) begin
        if (kept_q != '1) kept_d = kept_q + CNT_W'(1);
      end else begin
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q    <= '0;
      val_q  <= '0;
      mask_q <= '0;
      inv_q  <= 1'b0;
      rail_q <= RAIL_NULL;
      kept_q <= '0;
      drop_q <= '0;
    end else begin
      if (take) begin
        d_q    <= d_i;
        val_q  <= match_val;
        mask_q <= match_mask;
        inv_q  <= invert;
      end
      rail_q <= rail_d;
      kept_q <= kept_d;
      drop_q <= drop_d;
    end
  end

  assign ctl_a    = rail_q[0];
  assign ctl_b    = rail_q[1];
  assign kept_cnt = kept_q;
  assign drop_cnt = drop_q;

endmodule
